// File: rtl/rgb_led_pwm_pkg.sv
// Shared constants and elaboration-time helpers for the RGB LED PWM driver.
package rgb_led_pwm_pkg;

  // Each LED drives three channels: {R,G,B}
  localparam int unsigned ChanPerLed = 3;

  // PWM period in cycles for a given counter width (2**w - 1)
  function automatic int unsigned pwm_period(input int unsigned cnt_width);
    return (32'd1 << cnt_width) - 32'd1;
  endfunction

  // Last counter value before wrapping (period - 1)
  function automatic int unsigned pwm_max_cnt(input int unsigned cnt_width);
    return pwm_period(cnt_width) - 32'd1;
  endfunction

  // Phase offset of LED k: spreads LED turn-on instants evenly over the period
  function automatic int unsigned phase_offset(input int unsigned k,
                                               input int unsigned num_leds,
                                               input int unsigned cnt_width);
    return k * (pwm_period(cnt_width) / num_leds);
  endfunction

  // Width of an LED index
  function automatic int unsigned led_idx_w(input int unsigned num_leds);
    return (num_leds > 32'd1) ? $clog2(num_leds) : 32'd1;
  endfunction

  // Width of a channel index
  function automatic int unsigned chan_idx_w(input int unsigned num_leds);
    return (ChanPerLed * num_leds > 32'd1) ? $clog2(ChanPerLed * num_leds) : 32'd1;
  endfunction

endpackage

// File: rtl/rgb_led_pwm_chan.sv
// One LED worth of PWM: phase-shifted compare against the active duty, registered.
module rgb_led_pwm_chan
  import rgb_led_pwm_pkg::*;
#(
  parameter int unsigned CntWidth = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CntWidth-1:0]   cnt,
  input  logic [CntWidth-1:0]   off,
  input  logic [CntWidth-1:0]   duty,
  input  logic [ChanPerLed-1:0] en,
  output logic [ChanPerLed-1:0] pwm
);

  localparam logic [CntWidth:0] Period = (CntWidth+1)'(pwm_period(CntWidth));

  logic [CntWidth:0] sum;
  logic [CntWidth:0] ph;
  logic              lit;

  // Phase = (cnt + off) mod period; both operands < period, so one subtract suffices
  always_comb begin
    sum = {1'b0, cnt} + {1'b0, off};
    ph  = sum;
    if (sum >= Period) begin
      ph = sum - Period;
    end
    lit = (ph < {1'b0, duty});
  end

  // Register the gated compare so the pins never see combinational glitches
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm <= '0;
    end else begin
      pwm <= en & {ChanPerLed{lit}};
    end
  end

endmodule

// File: rtl/rgb_led_pwm.sv
// Phase-staggered PWM driver for the board RGB LEDs; duty/enable update only at period boundaries.
module rgb_led_pwm
  import rgb_led_pwm_pkg::*;
#(
  parameter int unsigned         NumLeds     = 4,
  parameter int unsigned         CntWidth    = 8,
  parameter logic [CntWidth-1:0] DefaultDuty = CntWidth'(32)
) (
  input  logic                            clk_sys_i,
  input  logic                            rst_sys_i,
  input  logic [ChanPerLed*NumLeds-1:0]   led_en_i,
  input  logic [CntWidth-1:0]             duty_i,
  input  logic                            duty_we_i,
  output logic [ChanPerLed*NumLeds-1:0]   rgb_led_o,
  output logic                            period_start_o
);

  localparam int unsigned         NumChan = ChanPerLed * NumLeds;
  localparam logic [CntWidth-1:0] MaxCnt  = CntWidth'(pwm_max_cnt(CntWidth));

  logic [CntWidth-1:0] cnt;
  logic [CntWidth-1:0] duty_shadow;
  logic [CntWidth-1:0] duty_act;
  logic [NumChan-1:0]  en_act;
  logic                at_boundary;

  assign at_boundary = (cnt == MaxCnt);

  // Free-running period counter, 0..MaxCnt
  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      cnt <= '0;
    end else if (at_boundary) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CntWidth'(1);
    end
  end

  // Shadow duty (last write wins) and active settings latched at the boundary
  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      duty_shadow <= DefaultDuty;
      duty_act    <= DefaultDuty;
      en_act      <= '0;
    end else begin
      if (duty_we_i) begin
        duty_shadow <= duty_i;
      end
      if (at_boundary) begin
        duty_act <= duty_we_i ? duty_i : duty_shadow;
        en_act   <= led_en_i;
      end
    end
  end

  // Pulse aligned with the first output cycle of each period
  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      period_start_o <= 1'b0;
    end else begin
      period_start_o <= (cnt == '0);
    end
  end

  // One PWM slice per LED with its own fixed phase offset
  for (genvar k = 0; k < NumLeds; k++) begin : g_led
    localparam logic [CntWidth-1:0] Off =
      CntWidth'(phase_offset(k, NumLeds, CntWidth));

    rgb_led_pwm_chan #(
      .CntWidth (CntWidth)
    ) u_chan (
      .clk  (clk_sys_i),
      .rst  (rst_sys_i),
      .cnt  (cnt),
      .off  (Off),
      .duty (duty_act),
      .en   (en_act[ChanPerLed*k +: ChanPerLed]),
      .pwm  (rgb_led_o[ChanPerLed*k +: ChanPerLed])
    );
  end

endmodule

// File: tb/tb_rgb_led_pwm.sv
// Bench for rgb_led_pwm: directed vectors, corner sequences and a randomized run against a reference model.
module tb_rgb_led_pwm;

  localparam int P  = 255;
  localparam int NL = 4;

  logic        clk;
  logic        rst_sys_i;
  logic [11:0] led_en_i;
  logic [7:0]  duty_i;
  logic        duty_we_i;
  logic [11:0] rgb_led_o;
  logic        period_start_o;

  int n_cmp  = 0;
  int n_fail = 0;

  rgb_led_pwm dut (
    .clk_sys_i      (clk),
    .rst_sys_i      (rst_sys_i),
    .led_en_i       (led_en_i),
    .duty_i         (duty_i),
    .duty_we_i      (duty_we_i),
    .rgb_led_o      (rgb_led_o),
    .period_start_o (period_start_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Time since reset drives everything; cnt is simply t mod P.
  int          m_t        = 0;
  int          m_last_cnt = -1;
  int          m_shadow   = 32;
  int          m_duty     = 32;
  logic [11:0] m_en       = '0;
  logic [11:0] exp_rgb    = '0;
  logic        exp_ps     = 1'b0;
  bit          m_valid    = 1'b0;

  function automatic logic [11:0] ref_rgb(input int c, input int duty, input logic [11:0] en);
    logic [11:0] r;
    r = '0;
    for (int k = 0; k < NL; k++) begin
      int ph;
      ph = (c + k * (P / NL)) % P;
      for (int ch = 0; ch < 3; ch++) begin
        r[3*k+ch] = en[3*k+ch] && (ph < duty);
      end
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst_sys_i) begin
      m_t = 0; m_last_cnt = -1; m_shadow = 32; m_duty = 32; m_en = '0;
      exp_rgb = '0; exp_ps = 1'b0; m_valid = 1'b1;
    end else begin
      int c;
      c       = m_t % P;
      exp_rgb = ref_rgb(c, m_duty, m_en);
      exp_ps  = (c == 0);
      if (c == P - 1) begin
        m_duty = duty_we_i ? int'(duty_i) : m_shadow;
        m_en   = led_en_i;
      end
      if (duty_we_i) m_shadow = int'(duty_i);
      m_t++;
      m_last_cnt = c;
    end
  end

  // Continuous comparison against the model on every cycle
  always @(negedge clk) begin
    if (m_valid) begin
      check("model_rgb", 32'(rgb_led_o), 32'(exp_rgb));
      check("model_period_start", 32'(period_start_o), 32'(exp_ps));
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_out_cnt(input int c);
    int g;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (m_last_cnt != c && g < 600);
    if (g >= 600) check("wait_cnt_timeout", 32'(m_last_cnt), 32'(c));
  endtask

  task automatic strobe(input logic [7:0] d);
    duty_i    = d;
    duty_we_i = 1'b1;
    @(negedge clk);
    duty_we_i = 1'b0;
  endtask

  task automatic count_window(input logic [11:0] mask, input logic [11:0] val, output int n);
    n = 0;
    for (int i = 0; i < P; i++) begin
      @(negedge clk);
      if ((rgb_led_o & mask) == val) n++;
    end
  endtask

  typedef struct {
    logic [7:0]  duty;
    logic [11:0] en;
    int          cnt;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int          cyc;
    int          n;
    logic [7:0]  prev_duty;
    logic [11:0] prev_en;
    bit          first;

    vecs.push_back('{8'd64,  12'hFFF,   0, 12'h03F});
    vecs.push_back('{8'd64,  12'hFFF,  63, 12'h007});
    vecs.push_back('{8'd64,  12'hFFF,  64, 12'h000});
    vecs.push_back('{8'd64,  12'hFFF,  65, 12'h000});
    vecs.push_back('{8'd64,  12'hFFF,  66, 12'hE00});
    vecs.push_back('{8'd64,  12'hFFF, 129, 12'hFC0});
    vecs.push_back('{8'd64,  12'hFFF, 130, 12'h1C0});
    vecs.push_back('{8'd64,  12'hFFF, 192, 12'h1F8});
    vecs.push_back('{8'd64,  12'hFFF, 193, 12'h038});
    vecs.push_back('{8'd64,  12'hFFF, 254, 12'h038});
    vecs.push_back('{8'd64,  12'h421,   0, 12'h021});
    vecs.push_back('{8'd0,   12'hFFF,   0, 12'h000});
    vecs.push_back('{8'd255, 12'hFFF, 254, 12'hFFF});
    vecs.push_back('{8'd255, 12'h924, 100, 12'h924});
    vecs.push_back('{8'd1,   12'hFFF,   0, 12'h007});
    vecs.push_back('{8'd32,  12'hFFF,  31, 12'h007});
    vecs.push_back('{8'd32,  12'hFFF,  32, 12'h000});

    rst_sys_i = 1'b1; led_en_i = '0; duty_i = '0; duty_we_i = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rgb", 32'(rgb_led_o), 32'h0);
    check("reset_period_start", 32'(period_start_o), 32'h0);

    // Outputs stay dark for a full period after release
    rst_sys_i = 1'b0; led_en_i = 12'hFFF;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (rgb_led_o == '0 && cyc < 600);
    check("first_high_cycle", 32'(cyc), 32'd256);

    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!period_start_o && cyc < 600);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!period_start_o && cyc < 600);
    check("period_start_interval", 32'(cyc), 32'd255);

    wait_out_cnt(254);
    count_window(12'h007, 12'h007, n);
    check("led0_high_cycles_d32", 32'(n), 32'd32);
    wait_out_cnt(254);
    count_window(12'hE00, 12'hE00, n);
    check("led3_high_cycles_d32", 32'(n), 32'd32);

    // Duty 0 written mid-period: current period unaffected, then dark
    wait_out_cnt(10);
    strobe(8'd0);
    wait_out_cnt(20);
    check("duty0_current_period", 32'(rgb_led_o), 32'h007);
    wait_out_cnt(254);
    count_window(12'hFFF, 12'h000, n);
    check("duty0_all_dark_cycles", 32'(n), 32'd255);

    // Full duty: no low cycle at all
    strobe(8'd255);
    wait_out_cnt(254);
    count_window(12'hFFF, 12'hFFF, n);
    check("duty255_all_on_cycles", 32'(n), 32'd255);

    // Table-driven vectors
    first = 1'b1; prev_duty = '0; prev_en = '0;
    foreach (vecs[i]) begin
      if (first || vecs[i].duty != prev_duty || vecs[i].en != prev_en) begin
        led_en_i = vecs[i].en;
        strobe(vecs[i].duty);
        wait_out_cnt(254);
        prev_duty = vecs[i].duty; prev_en = vecs[i].en; first = 1'b0;
      end
      wait_out_cnt(vecs[i].cnt);
      check($sformatf("vec%0d_d%0d_c%0d", i, vecs[i].duty, vecs[i].cnt),
            32'(rgb_led_o), 32'(vecs[i].exp));
    end

    // Write-through when the strobe lands on the boundary cycle
    led_en_i = 12'hFFF;
    strobe(8'd255);
    wait_out_cnt(254);
    wait_out_cnt(253);
    strobe(8'd100);
    count_window(12'h007, 12'h007, n);
    check("write_through_d100", 32'(n), 32'd100);

    // Two writes in one period: the later wins
    wait_out_cnt(10);
    strobe(8'd10);
    wait_out_cnt(50);
    strobe(8'd200);
    wait_out_cnt(254);
    count_window(12'h007, 12'h007, n);
    check("last_write_wins_d200", 32'(n), 32'd200);

    // Enable drop mid-period: window completes, then off
    led_en_i = 12'h001;
    strobe(8'd32);
    wait_out_cnt(254);
    n = 0;
    for (int i = 0; i < P; i++) begin
      @(negedge clk);
      if (rgb_led_o[0]) n++;
      if (i == 4) led_en_i = 12'h000;
    end
    check("en_drop_current_window", 32'(n), 32'd32);
    count_window(12'h001, 12'h001, n);
    check("en_drop_next_period", 32'(n), 32'd0);

    // Reset in mid-period with outputs high
    led_en_i = 12'hFFF;
    strobe(8'd255);
    wait_out_cnt(254);
    wait_out_cnt(119);
    check("pre_reset_high", 32'(rgb_led_o), 32'hFFF);
    rst_sys_i = 1'b1;
    @(negedge clk);
    check("midreset_rgb", 32'(rgb_led_o), 32'h0);
    check("midreset_period_start", 32'(period_start_o), 32'h0);
    rst_sys_i = 1'b0;
    @(negedge clk);
    check("restart_period_start", 32'(period_start_o), 32'h1);
    check("restart_rgb_dark", 32'(rgb_led_o), 32'h0);

    // Randomized traffic, checked cycle by cycle by the model
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = int'($urandom_range(0, 2));
      duty_we_i = ($urandom_range(0, 39) == 0);
      duty_i    = (r == 0) ? 8'd0 : (r == 1) ? 8'd255 : 8'($urandom);
      if ($urandom_range(0, 96) == 0) led_en_i = 12'($urandom);
      rst_sys_i = ($urandom_range(0, 1499) == 0);
      @(negedge clk);
    end
    duty_we_i = 1'b0; rst_sys_i = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
